// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running raster timing generator for the pixel clock
// domain. Presents DrawX/DrawY, the active-video flag (blank), active-low
// monitor sync pulses, line/frame strobes and a completed-frame counter.
//
// Optional build macro: VGA_SYNC_DELAY_EN
//   When defined, hs, vs and blank pass through one extra register stage so
//   they line up with RGB that drawers register against DrawX/DrawY. DrawX,
//   DrawY, line_start, frame_start and frame_count are never delayed.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic        vga_clk,
  input  logic        reset,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        blank,
  output logic        hs,
  output logic        vs,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam logic [9:0] H_LAST       = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST       = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_ACTIVE_END = 10'(H_VISIBLE);
  localparam logic [9:0] V_ACTIVE_END = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START     = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END       = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START     = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END       = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [9:0]  r_hCount;
  logic [9:0]  r_vCount;
  logic        r_hsLive;
  logic        r_vsLive;
  logic        r_blankLive;
  logic        r_lineStart;
  logic        r_frameStart;
  logic [15:0] r_frameCount;

  logic [9:0]  w_hCountNext;
  logic [9:0]  w_vCountNext;
  logic        w_hWrap;
  logic        w_vWrap;
  logic        w_atOrigin;

  // Next raster position: hc wraps every line, vc advances only when hc wraps
  always_comb begin
    w_hWrap      = (r_hCount == H_LAST);
    w_vWrap      = (r_vCount == V_LAST);
    w_hCountNext = w_hWrap ? 10'd0 : (r_hCount + 10'd1);
    w_vCountNext = r_vCount;
    if (w_hWrap) begin
      w_vCountNext = w_vWrap ? 10'd0 : (r_vCount + 10'd1);
    end
    w_atOrigin   = (w_hCountNext == 10'd0) && (w_vCountNext == 10'd0);
  end

  // Counters plus sync/blank/strobes decoded from the next position, so every flop describes the same pixel
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_hCount     <= 10'd0;
      r_vCount     <= 10'd0;
      r_hsLive     <= 1'b1;
      r_vsLive     <= 1'b1;
      r_blankLive  <= 1'b0;
      r_lineStart  <= 1'b0;
      r_frameStart <= 1'b0;
      r_frameCount <= 16'd0;
    end else begin
      r_hCount     <= w_hCountNext;
      r_vCount     <= w_vCountNext;
      r_hsLive     <= !((w_hCountNext >= HS_START) && (w_hCountNext < HS_END));
      r_vsLive     <= !((w_vCountNext >= VS_START) && (w_vCountNext < VS_END));
      r_blankLive  <= (w_hCountNext < H_ACTIVE_END) && (w_vCountNext < V_ACTIVE_END);
      r_lineStart  <= (w_hCountNext == 10'd0);
      r_frameStart <= w_atOrigin;
      if (w_atOrigin) begin
        r_frameCount <= r_frameCount + 16'd1;
      end
    end
  end

  assign DrawX       = r_hCount;
  assign DrawY       = r_vCount;
  assign line_start  = r_lineStart;
  assign frame_start = r_frameStart;
  assign frame_count = r_frameCount;

`ifdef VGA_SYNC_DELAY_EN
  logic r_hsDly;
  logic r_vsDly;
  logic r_blankDly;

  // Extra stage so sync/blank match the one-cycle latency of drawers' registered RGB
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_hsDly    <= 1'b1;
      r_vsDly    <= 1'b1;
      r_blankDly <= 1'b0;
    end else begin
      r_hsDly    <= r_hsLive;
      r_vsDly    <= r_vsLive;
      r_blankDly <= r_blankLive;
    end
  end

  assign hs    = r_hsDly;
  assign vs    = r_vsDly;
  assign blank = r_blankDly;
`else
  assign hs    = r_hsLive;
  assign vs    = r_vsLive;
  assign blank = r_blankLive;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench for vga_timing_gen. A default-size
// instance covers reset and one full 640x480 line; a scaled-down instance
// (32 clocks/line, 20 lines/frame) covers frame-level behaviour within a
// short run. Both share clock and reset.
`timescale 1ns/1ps
module tb_vga_timing_gen;

`ifdef VGA_SYNC_DELAY_EN
  localparam int DLY = 1;
`else
  localparam int DLY = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic [9:0]  fX, fY, sX, sY;
  logic        fBlank, fHs, fVs, fLs, fFs;
  logic        sBlank, sHs, sVs, sLs, sFs;
  logic [15:0] fFc, sFc;

  int checkCount = 0;
  int passCount  = 0;

  // Free-running pixel clock
  always #5 clk = ~clk;

  vga_timing_gen dutFull (
    .vga_clk(clk), .reset(reset), .DrawX(fX), .DrawY(fY), .blank(fBlank),
    .hs(fHs), .vs(fVs), .line_start(fLs), .frame_start(fFs), .frame_count(fFc)
  );

  vga_timing_gen #(
    .H_VISIBLE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
    .V_VISIBLE(10), .V_FP(2), .V_SYNC(3), .V_BP(5)
  ) dutSmall (
    .vga_clk(clk), .reset(reset), .DrawX(sX), .DrawY(sY), .blank(sBlank),
    .hs(sHs), .vs(sVs), .line_start(sLs), .frame_start(sFs), .frame_count(sFc)
  );

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed == expected) passCount++;
    else $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
  endtask

  // Hold reset for the given number of rising edges, return on the following falling edge
  task automatic applyStimulus(input int cycles);
    reset = 1'b1;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
  endtask

  // Measurement state
  int  fHsLow = 0, fHsFallX = -1, fBlankFallX = -1, fBlankFallY = -1;
  int  fLsCount = 0, fLsX = -1, fLsY = -1;
  int  sHsLow = 0, sHsFallX = -1;
  int  fsCount = 0, fsFirstK = -1, fsSecondK = -1, fsPrevX = -1, fsPrevY = -1;
  int  fsX = -1, fsY = -1, fsNoLs = 0;
  int  sBlankHigh = 0, sVsLow = 0, sVsFallX = -1, sVsFallY = -1;
  int  postResetFs = 0;
  bit  reached = 0;
  logic prevFHs, prevFBlank, prevSHs, prevSVs;
  logic [9:0] prevSX, prevSY;

  // Main directed sequence
  initial begin
    $display("[TB] starting, sync delay stage = %0d", DLY);
    applyStimulus(5);

    checkOutput("rstFullDrawX", fX, 0);
    checkOutput("rstFullDrawY", fY, 0);
    checkOutput("rstFullHs", fHs, 1);
    checkOutput("rstFullVs", fVs, 1);
    checkOutput("rstFullBlank", fBlank, 0);
    checkOutput("rstFullLineStart", fLs, 0);
    checkOutput("rstFullFrameStart", fFs, 0);
    checkOutput("rstFullFrameCount", fFc, 0);
    checkOutput("rstSmallDrawX", sX, 0);
    checkOutput("rstSmallHs", sHs, 1);
    checkOutput("rstSmallVs", sVs, 1);
    checkOutput("rstSmallBlank", sBlank, 0);

    prevFHs = fHs; prevFBlank = fBlank; prevSHs = sHs; prevSVs = sVs;
    prevSX = sX; prevSY = sY;
    reset = 1'b0;

    for (int k = 1; k <= 1300; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checkOutput("firstDrawX", fX, 1);
        checkOutput("firstDrawY", fY, 0);
        checkOutput("firstBlank", fBlank, 1 - DLY);
        checkOutput("firstHs", fHs, 1);
        checkOutput("firstVs", fVs, 1);
      end
      // Full-size horizontal line
      if (k <= 800 && !fHs) fHsLow++;
      if (fHsFallX < 0 && prevFHs && !fHs) fHsFallX = fX;
      if (fBlankFallX < 0 && prevFBlank && !fBlank) begin
        fBlankFallX = fX;
        fBlankFallY = fY;
      end
      if (fLs) begin
        fLsCount++;
        fLsX = fX;
        fLsY = fY;
      end
      // Scaled instance: line, frame and vertical window
      if (k <= 32 && !sHs) sHsLow++;
      if (sHsFallX < 0 && prevSHs && !sHs) sHsFallX = sX;
      if (sFs) begin
        fsCount++;
        if (fsCount == 1) begin
          fsFirstK = k; fsPrevX = prevSX; fsPrevY = prevSY; fsX = sX; fsY = sY;
        end else if (fsCount == 2) begin
          fsSecondK = k;
        end
        if (!sLs) fsNoLs++;
      end
      if (k >= 640 && k < 1280) begin
        if (sBlank) sBlankHigh++;
        if (!sVs) sVsLow++;
      end
      if (sVsFallX < 0 && prevSVs && !sVs) begin
        sVsFallX = sX;
        sVsFallY = sY;
      end
      prevFHs = fHs; prevFBlank = fBlank; prevSHs = sHs; prevSVs = sVs;
      prevSX = sX; prevSY = sY;
    end

    checkOutput("fullHsLowPerLine", fHsLow, 96);
    checkOutput("fullHsFallX", fHsFallX, 656 + DLY);
    checkOutput("fullBlankFallX", fBlankFallX, 640 + DLY);
    checkOutput("fullBlankFallY", fBlankFallY, 0);
    checkOutput("fullLineStartCount", fLsCount, 1);
    checkOutput("fullLineStartX", fLsX, 0);
    checkOutput("fullLineStartY", fLsY, 1);
    checkOutput("fullFrameCount", fFc, 0);
    checkOutput("smallHsLowPerLine", sHsLow, 5);
    checkOutput("smallHsFallX", sHsFallX, 23 + DLY);
    checkOutput("frameStartCount", fsCount, 2);
    checkOutput("firstFrameStartCycle", fsFirstK, 640);
    checkOutput("frameStartPeriod", fsSecondK - fsFirstK, 640);
    checkOutput("wrapFromX", fsPrevX, 31);
    checkOutput("wrapFromY", fsPrevY, 19);
    checkOutput("wrapToX", fsX, 0);
    checkOutput("wrapToY", fsY, 0);
    checkOutput("frameStartWithoutLineStart", fsNoLs, 0);
    checkOutput("smallFrameCount", sFc, 2);
    checkOutput("smallBlankPerFrame", sBlankHigh, 200);
    checkOutput("smallVsLowPerFrame", sVsLow, 96);
    checkOutput("smallVsFallX", sVsFallX, DLY);
    checkOutput("smallVsFallY", sVsFallY, 12);

    // Mid-frame reset at scaled position (10,5), bounded search
    for (int n = 0; n < 700 && !reached; n++) begin
      @(negedge clk);
      if (sX == 10'd10 && sY == 10'd5) reached = 1;
    end
    checkOutput("midResetReached", int'(reached), 1);

    applyStimulus(1);
    checkOutput("midRstDrawX", sX, 0);
    checkOutput("midRstDrawY", sY, 0);
    checkOutput("midRstFrameCount", sFc, 0);
    checkOutput("midRstFrameStart", sFs, 0);
    checkOutput("midRstLineStart", sLs, 0);
    checkOutput("midRstHs", sHs, 1);
    checkOutput("midRstVs", sVs, 1);
    checkOutput("midRstBlank", sBlank, 0);
    checkOutput("midRstFullFrameCount", fFc, 0);
    reset = 1'b0;

    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (n == 1) begin
        checkOutput("postRstDrawX", sX, 1);
        checkOutput("postRstDrawY", sY, 0);
      end
      if (sFs) postResetFs++;
    end
    checkOutput("postRstFrameStarts", postResetFs, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
